// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter: one digit per clock, most significant first.
// Valid/ready on both sides, one conversion in flight, flags any nybble above 9.
module bcd_to_bin_seq #(
   parameter int unsigned N = 8,
   parameter int unsigned W = 27
) (
   input  logic             rst,
   input  logic             clk,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4*N-1:0]   i,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     o,
   output logic             err
);

   localparam int unsigned BW = 4 * N;
   localparam int unsigned CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CONV = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic            r_in_ready;
   logic            r_out_valid;
   logic            w_in_ready_nxt;
   logic            w_out_valid_nxt;
   logic [BW-1:0]   r_sr;
   logic [CW-1:0]   r_cnt;
   logic [W-1:0]    r_acc;
   logic            r_err;
   logic [3:0]      w_digit;
   logic            w_accept;

   assign w_accept = in_valid & r_in_ready & (r_state == S_IDLE);
   assign w_digit  = r_sr[BW-1 -: 4];

   // State register; handshake flags are registered decodes of the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_in_ready  <= w_in_ready_nxt;
         r_out_valid <= w_out_valid_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept)           w_state_nxt = S_CONV;
         S_CONV:  if (r_cnt == CW'(1))    w_state_nxt = S_DONE;
         S_DONE:  if (out_ready)          w_state_nxt = S_IDLE;
         default:                         w_state_nxt = S_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      w_in_ready_nxt  = 1'b0;
      w_out_valid_nxt = 1'b0;
      if (w_state_nxt == S_IDLE) w_in_ready_nxt  = 1'b1;
      if (w_state_nxt == S_DONE) w_out_valid_nxt = 1'b1;
   end

   // Datapath: acc*10 + digit via shift-add, wrapping at W bits
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sr  <= '0;
         r_cnt <= '0;
         r_acc <= '0;
         r_err <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_sr  <= i;
                  r_cnt <= CW'(N);
                  r_acc <= '0;
                  r_err <= 1'b0;
               end
            end
            S_CONV: begin
               r_acc <= (r_acc << 3) + (r_acc << 1) + W'(w_digit);
               r_err <= r_err | (w_digit > 4'd9);
               r_sr  <= {r_sr[BW-5:0], 4'h0};
               r_cnt <= r_cnt - CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign o         = r_acc;
   assign err       = r_err;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Testbench for bcd_to_bin_seq: directed scenarios plus a random sweep
// checked against a positional-value decimal model.
module tb_bcd_to_bin_seq;

   localparam int N  = 8;
   localparam int W  = 27;
   localparam int BW = 4 * N;

   logic           rst;
   logic           clk;
   logic           in_valid;
   logic           in_ready;
   logic [BW-1:0]  i_bcd;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   dut_o;
   logic           dut_err;

   int total = 0;
   int bad   = 0;

   bcd_to_bin_seq #(.N(N), .W(W)) dut (
      .rst       (rst),
      .clk       (clk),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .i         (i_bcd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .o         (dut_o),
      .err       (dut_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Decimal value as sum of digit * 10^position, reduced mod 2^W
   function automatic void ref_model(input logic [BW-1:0] op,
                                     output logic [W-1:0] val, output logic e);
      longint unsigned sum;
      longint unsigned scale;
      sum   = 0;
      scale = 1;
      e     = 1'b0;
      for (int k = 0; k < N; k++) begin
         longint unsigned d;
         d = longint'(op[k*4 +: 4]);
         sum = sum + d * scale;
         scale = scale * 10;
         if (d > 9) e = 1'b1;
      end
      val = W'(sum);
   endfunction

   function automatic logic [BW-1:0] rand_bcd();
      logic [BW-1:0] v;
      v = '0;
      for (int k = 0; k < N; k++) v[k*4 +: 4] = 4'($urandom_range(0, 9));
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction with optional result stall; junk_valid drives in_valid during the stall
   task automatic do_conv(input logic [BW-1:0] op, input int stall, input bit junk_valid,
                          input string tag);
      int cyc;
      logic [W-1:0] exp_o;
      logic exp_e;
      ref_model(op, exp_o, exp_e);
      out_ready = (stall == 0);
      cyc = 0;
      while (!in_ready && cyc < 100) begin
         tick();
         cyc++;
      end
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL %s in_ready_wait got=%b want=1", tag, in_ready);
      end
      i_bcd    = op;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      i_bcd    = BW'($urandom);
      cyc = 0;
      while (!out_valid && cyc < 100) begin
         total++;
         if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s in_ready_busy got=%b want=0", tag, in_ready);
         end
         tick();
         cyc++;
      end
      total++;
      if (cyc !== N) begin
         bad++;
         $display("FAIL %s latency got=%0d want=%0d", tag, cyc, N);
      end
      total++;
      if (dut_o !== exp_o || dut_err !== exp_e) begin
         bad++;
         $display("FAIL %s result op=%h got o=%0d err=%b want o=%0d err=%b",
                  tag, op, dut_o, dut_err, exp_o, exp_e);
      end
      for (int k = 0; k < stall; k++) begin
         if (junk_valid) begin
            in_valid = 1'b1;
            i_bcd    = rand_bcd();
         end
         tick();
         total++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || dut_o !== exp_o || dut_err !== exp_e) begin
            bad++;
            $display("FAIL %s stall%0d got v=%b rdy=%b o=%0d err=%b want v=1 rdy=0 o=%0d err=%b",
                     tag, k, out_valid, in_ready, dut_o, dut_err, exp_o, exp_e);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL %s handoff got v=%b rdy=%b want v=0 rdy=1", tag, out_valid, in_ready);
      end
      total++;
      if (dut_o !== exp_o || dut_err !== exp_e) begin
         bad++;
         $display("FAIL %s hold_after got o=%0d err=%b want o=%0d err=%b",
                  tag, dut_o, dut_err, exp_o, exp_e);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      i_bcd = '0;
      repeat (3) tick();
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || dut_o !== '0 || dut_err !== 1'b0) begin
         bad++;
         $display("FAIL reset_vals got rdy=%b v=%b o=%0d err=%b want 0 0 0 0",
                  in_ready, out_valid, dut_o, dut_err);
      end
      rst = 1'b0;
      tick();
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_release got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
      end
   endtask

   task automatic test_basic();
      do_conv(32'h12345678, 0, 1'b0, "basic");
   endtask

   task automatic test_back_to_back();
      int cyc;
      out_ready = 1'b1;
      i_bcd    = 32'h99999999;
      in_valid = 1'b1;
      tick();
      i_bcd = 32'h00000000;
      cyc = 0;
      while (!out_valid && cyc < 100) begin
         tick();
         cyc++;
      end
      total++;
      if (cyc !== N || dut_o !== 27'd99999999 || dut_err !== 1'b0) begin
         bad++;
         $display("FAIL b2b_first got lat=%0d o=%0d err=%b want lat=%0d o=99999999 err=0",
                  cyc, dut_o, dut_err, N);
      end
      tick();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL b2b_idle got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
      end
      tick();
      in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 100) begin
         tick();
         cyc++;
      end
      total++;
      if (cyc !== N || dut_o !== '0 || dut_err !== 1'b0) begin
         bad++;
         $display("FAIL b2b_second got lat=%0d o=%0d err=%b want lat=%0d o=0 err=0",
                  cyc, dut_o, dut_err, N);
      end
      tick();
   endtask

   task automatic test_err();
      do_conv(32'h0000000A, 0, 1'b0, "err_a");
      do_conv(32'h00000042, 0, 1'b0, "err_clear");
      do_conv(32'hFFFFFFFF, 1, 1'b0, "err_wrap");
   endtask

   task automatic test_backpressure();
      do_conv(32'h00012345, 5, 1'b1, "backpressure");
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1;
      i_bcd     = 32'h87654321;
      in_valid  = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (out_valid !== 1'b0 || dut_o !== '0 || dut_err !== 1'b0 || in_ready !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid got v=%b o=%0d err=%b rdy=%b want 0 0 0 0",
                  out_valid, dut_o, dut_err, in_ready);
      end
      rst = 1'b0;
      tick();
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_idle got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
      end
      do_conv(32'h00000007, 0, 1'b0, "after_reset");
   endtask

   task automatic test_random();
      for (int n = 0; n < 1000; n++) begin
         do_conv(rand_bcd(), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "random");
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_err();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
